rgb2gray_pipe: RTL and testbench

RGB2GRAY_PIPE -- requirements
Module: rgb2gray_pipe

---
 rtl/rgb2gray_pkg.sv | 20 ++
 rtl/rgb2gray_mac.sv | 59 +++++
 rtl/rgb2gray_pipe.sv | 82 ++++++++
 tb/tb_rgb2gray_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2gray_pkg.sv
// rgb2gray_pkg: luma coefficients, shift amount and the pipeline stage record.
// RGB2GRAY_ROUND_EN selects round-to-nearest (K=128) instead of truncation (K=0).
package rgb2gray_pkg;
    localparam int COEF_R = 77;
    localparam int COEF_G = 150;
    localparam int COEF_B = 29;
    localparam int SHIFT = 8;
    localparam int STAGE_DATA_W = 32;
`ifdef RGB2GRAY_ROUND_EN
    localparam int ROUND_K = 128;
`else
    localparam int ROUND_K = 0;
`endif
    // Data field is sized for the widest supported accumulator (DATA_W <= 23).
    typedef struct packed {
        logic                    valid;
        logic                    last;
        logic [STAGE_DATA_W-1:0] data;
    } stage_t;
endpackage

// File: rtl/rgb2gray_mac.sv
// rgb2gray_mac: stages S1 (three coefficient products) and S2 (rounded sum).
// Rounding constant comes from the package (RGB2GRAY_ROUND_EN).
module rgb2gray_mac
    import rgb2gray_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    output stage_t            s2
);
    localparam int ACC_W = DATA_W + SHIFT;

    logic [ACC_W-1:0] p_r_q, p_g_q, p_b_q, p_r_d, p_g_d, p_b_d, sum;
    logic             s1_valid_q, s1_last_q, s1_valid_d, s1_last_d;
    stage_t           s2_q, s2_d;

    assign sum = p_r_q + p_g_q + p_b_q + ACC_W'(ROUND_K);
    assign s2 = s2_q;

    always_comb begin
        p_r_d = en ? ACC_W'(COEF_R) * ACC_W'(in_r) : p_r_q;
        p_g_d = en ? ACC_W'(COEF_G) * ACC_W'(in_g) : p_g_q;
        p_b_d = en ? ACC_W'(COEF_B) * ACC_W'(in_b) : p_b_q;
        s1_valid_d = clr ? 1'b0 : en ? in_valid : s1_valid_q;
        s1_last_d = en ? in_last : s1_last_q;
        s2_d = s2_q;
        if (en) begin
            s2_d.last = s1_last_q;
            s2_d.data = STAGE_DATA_W'(sum);
        end
        s2_d.valid = clr ? 1'b0 : en ? s1_valid_q : s2_q.valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r_q <= '0;
            p_g_q <= '0;
            p_b_q <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q <= 1'b0;
            s2_q <= '0;
        end else begin
            p_r_q <= p_r_d;
            p_g_q <= p_g_d;
            p_b_q <= p_b_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q <= s1_last_d;
            s2_q <= s2_d;
        end
    end
endmodule

// File: rtl/rgb2gray_pipe.sv
// rgb2gray_pipe: 3-stage RGB to luma pipeline with frame tagging and frame counter.
// Define RGB2GRAY_ROUND_EN for round-to-nearest luma; default truncates.
module rgb2gray_pipe
    import rgb2gray_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAME_PIXELS = 250000,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int ACC_W = DATA_W + SHIFT;
    localparam int IDX_W = $clog2(FRAME_PIXELS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_PIXELS - 1);

    logic             en, in_fire, out_fire, idx_wrap, unused_bits;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    stage_t           s2, s3_q, s3_d;

    // Whole pipeline advances together; clr blocks acceptance and any output transfer.
    assign en = !s3_q.valid | out_ready;
    assign in_ready = en & !clr;
    assign in_fire = in_valid & in_ready;
    assign out_fire = s3_q.valid & out_ready & !clr;
    assign idx_wrap = idx_q == IDX_LAST;

    assign out_valid = s3_q.valid;
    assign out_last = s3_q.last;
    assign out_data = s3_q.data[DATA_W-1:0];
    assign frame_cnt = frame_cnt_q;
    assign unused_bits = ^{s2.data[STAGE_DATA_W-1:ACC_W], s2.data[SHIFT-1:0],
                           s3_q.data[STAGE_DATA_W-1:DATA_W]};

    rgb2gray_mac #(.DATA_W(DATA_W)) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .in_valid (in_fire),
        .in_last  (idx_wrap),
        .in_r     (in_r),
        .in_g     (in_g),
        .in_b     (in_b),
        .s2       (s2)
    );

    always_comb begin
        idx_d = clr ? '0 : !in_fire ? idx_q : idx_wrap ? '0 : idx_q + 1'b1;
        frame_cnt_d = clr ? '0 : frame_cnt_q + CNT_W'(out_fire & s3_q.last);
        s3_d = s3_q;
        if (en) begin
            s3_d.last = s2.last;
            s3_d.data = STAGE_DATA_W'(s2.data[ACC_W-1:SHIFT]);
        end
        s3_d.valid = clr ? 1'b0 : en ? s2.valid : s3_q.valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            frame_cnt_q <= '0;
            s3_q <= '0;
        end else begin
            idx_q <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            s3_q <= s3_d;
        end
    end
endmodule

// File: tb/tb_rgb2gray_pipe.sv
// tb_rgb2gray_pipe: directed and randomized checks of rgb2gray_pipe against a luma queue model.
// Honours RGB2GRAY_ROUND_EN for the expected rounding.
module tb_rgb2gray_pipe;
    localparam int DATA_W = 8;
    localparam int FP = 4;
    localparam int CNT_W = 16;
`ifdef RGB2GRAY_ROUND_EN
    localparam int K = 128;
    localparam int RED_Y = 77;
`else
    localparam int K = 0;
    localparam int RED_Y = 76;
`endif

    logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 1;
    logic [DATA_W-1:0] in_r = 0, in_g = 0, in_b = 0;
    logic in_ready, out_valid, out_last;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0] frame_cnt;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t q[$];
    exp_t e;
    bit last_log[$];
    int n_chk = 0, n_pass = 0;
    int m_idx = 0, m_fc = 0, pops = 0, p_data = 0;
    bit p_valid = 0, p_ready = 0, p_clr = 0, p_last = 0;

    rgb2gray_pipe #(.DATA_W(DATA_W), .FRAME_PIXELS(FP), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic int luma(int r, int g, int b);
        return (77 * r + 150 * g + 29 * b + K) >> 8;
    endfunction

    task automatic chk(string name, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Inputs and outputs are stable at the falling edge; decide what the next rising edge transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_idx = 0;
            m_fc = 0;
            p_valid = 0;
        end else begin
            chk("frame_cnt", int'(frame_cnt), m_fc % (1 << CNT_W));
            chk("in_ready", int'(in_ready), int'((!out_valid || out_ready) && !clr));
            if (p_valid && !p_ready && !p_clr) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), p_data);
                chk("hold_last", int'(out_last), int'(p_last));
            end
            if (clr) begin
                q.delete();
                m_idx = 0;
                m_fc = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("spurious_out", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("out_data", int'(out_data), e.data);
                        chk("out_last", int'(out_last), int'(e.last));
                        if (e.last) m_fc++;
                        pops++;
                        last_log.push_back(out_last);
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back('{luma(int'(in_r), int'(in_g), int'(in_b)), m_idx == FP - 1});
                    m_idx = (m_idx + 1) % FP;
                end
            end
            p_valid = out_valid;
            p_ready = out_ready;
            p_clr = clr;
            p_data = int'(out_data);
            p_last = out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int r, int g, int b);
        bit acc = 0;
        in_r = DATA_W'(r);
        in_g = DATA_W'(g);
        in_b = DATA_W'(b);
        in_valid = 1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        in_valid = 0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            done = q.size() == 0 && !out_valid;
        end
        chk("drain", int'(done), 1);
    endtask

    task automatic lit(int r, int g, int b, int y, bit last);
        send(r, g, b);
        step();
        chk("lat_early", int'(out_valid), 0);
        step();
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_data", int'(out_data), y);
        chk("lat_last", int'(out_last), int'(last));
        step();
    endtask

    task automatic pulse_clr();
        clr = 1;
        step();
        clr = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, sent, c;
        bit acc;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        step();
        rst_n = 1;
        chk("ready_after_rst", int'(in_ready), 1);

        lit(255, 0, 0, RED_Y, 0);
        lit(255, 255, 255, 255, 0);
        lit(0, 0, 0, 0, 0);
        lit(0, 255, 0, 149, 1);
        chk("frame_after_4", int'(frame_cnt), 1);

        base = pops;
        sent = 0;
        c = 0;
        in_r = DATA_W'($urandom);
        in_g = DATA_W'($urandom);
        in_b = DATA_W'($urandom);
        in_valid = 1;
        while (sent < 20 && c < 200) begin
            out_ready = !(c >= 6 && c <= 10);
            @(negedge clk);
            if (c >= 6 && c <= 10) chk("stall_in_ready", int'(in_ready), 0);
            acc = in_ready;
            step();
            c++;
            if (acc) begin
                sent++;
                in_r = DATA_W'($urandom);
                in_g = DATA_W'($urandom);
                in_b = DATA_W'($urandom);
            end
        end
        in_valid = 0;
        out_ready = 1;
        drain();
        chk("stream_count", pops - base, 20);

        pulse_clr();
        last_log.delete();
        for (int i = 0; i < 9; i++) send(int'($urandom % 256), int'($urandom % 256), int'($urandom % 256));
        drain();
        chk("frame9_count", last_log.size(), 9);
        for (int i = 0; i < 9 && i < last_log.size(); i++)
            chk("frame9_last", int'(last_log[i]), int'(i == 3 || i == 7));
        chk("frame9_cnt", int'(frame_cnt), 2);

        send(10, 20, 30);
        send(40, 50, 60);
        clr = 1;
        in_valid = 1;
        in_r = 8'd200;
        @(negedge clk);
        chk("clr_rejects", int'(in_ready), 0);
        step();
        clr = 0;
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("clr_dropped", int'(out_valid), 0);
            step();
        end
        chk("clr_frame_cnt", int'(frame_cnt), 0);
        last_log.delete();
        for (int i = 0; i < 4; i++) send(0, 255, 0);
        drain();
        chk("clr_count", last_log.size(), 4);
        for (int i = 0; i < 4 && i < last_log.size(); i++)
            chk("clr_last", int'(last_log[i]), int'(i == 3));
        chk("clr_frame_after", int'(frame_cnt), 1);

        out_ready = 0;
        send(1, 2, 3);
        send(4, 5, 6);
        send(7, 8, 9);
        step();
        chk("stall_before_rst", int'(out_valid), 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_data", int'(out_data), 0);
        chk("async_rst_frame", int'(frame_cnt), 0);
        step();
        step();
        rst_n = 1;
        out_ready = 1;
        chk("ready_after_rst2", int'(in_ready), 1);
        last_log.delete();
        for (int i = 0; i < 4; i++) send(int'($urandom % 256), int'($urandom % 256), int'($urandom % 256));
        drain();
        chk("rst_frame_count", last_log.size(), 4);
        for (int i = 0; i < 4 && i < last_log.size(); i++)
            chk("rst_frame_last", int'(last_log[i]), int'(i == 3));

        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom % 4) != 0;
            in_r = ($urandom % 5 == 0) ? 8'hFF : DATA_W'($urandom);
            in_g = ($urandom % 5 == 0) ? 8'hFF : DATA_W'($urandom);
            in_b = ($urandom % 5 == 0) ? 8'h00 : DATA_W'($urandom);
            out_ready = ($urandom % 3) != 0;
            clr = ($urandom % 150) == 0;
            step();
        end
        clr = 0;
        in_valid = 0;
        out_ready = 1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
